xbar_route_initiator: RTL

- Control-side initiator for the packet-routing crossbar.
- Accepts route requests from a config/host source: input index, output index and packet count.
- Issues one control word to the crossbar's control val/rdy port per request, then holds the route while counting completed transfers.
- Returns a completion/error response. Sits between the router's scheduler and the crossbar control port.

---
 rtl/xbar_pkg.sv | 52 +++++
 rtl/xbar_route_counter.sv | 29 ++
 rtl/xbar_route_initiator.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/xbar_pkg.sv
// Shared types, default configuration and control-word packing for the crossbar
// route initiator.
package xbar_pkg;

  localparam int DEF_N_INPUTS          = 2;
  localparam int DEF_N_OUTPUTS         = 2;
  localparam int DEF_CONTROL_BIT_WIDTH = 42;
  localparam int DEF_CNT_W             = 8;

  localparam int IW     = $clog2(DEF_N_INPUTS);
  localparam int OW     = $clog2(DEF_N_OUTPUTS);
  localparam int REQ_W  = IW + OW + DEF_CNT_W;
  localparam int RESP_W = 1 + IW + OW;

  // Widest control word pack_control can build; callers size-cast the result.
  localparam int MAX_CW = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    ACTIVE = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic [IW-1:0]        in_sel;
    logic [OW-1:0]        out_sel;
    logic [DEF_CNT_W-1:0] count;
  } route_req_t;

  typedef struct packed {
    logic          err;
    logic [IW-1:0] in_sel;
    logic [OW-1:0] out_sel;
  } route_resp_t;

  // in_sel lands in the top iw bits, out_sel directly below it, and the rest is zero.
  function automatic logic [MAX_CW-1:0] pack_control(
    input int unsigned cw,
    input int unsigned iw,
    input int unsigned ow,
    input logic [31:0] in_sel,
    input logic [31:0] out_sel
  );
    logic [MAX_CW-1:0] in_part;
    logic [MAX_CW-1:0] out_part;
    in_part  = MAX_CW'(in_sel & ((32'd1 << iw) - 32'd1));
    out_part = MAX_CW'(out_sel & ((32'd1 << ow) - 32'd1));
    return (in_part << (cw - iw)) | (out_part << (cw - iw - ow));
  endfunction

endpackage

// File: rtl/xbar_route_counter.sv
// Loadable down-counter that tracks the packets still owed on the current route.
module xbar_route_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         is_zero,
  output logic         is_one
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign is_zero = (count_reg == '0);
  assign is_one  = (count_reg == W'(1));

endmodule

// File: rtl/xbar_route_initiator.sv
// Route initiator: accepts one route request, issues the crossbar control word,
// counts the routed packets and returns a completion or error response.
module xbar_route_initiator
  import xbar_pkg::*;
#(
  parameter int N_INPUTS          = DEF_N_INPUTS,
  parameter int N_OUTPUTS         = DEF_N_OUTPUTS,
  parameter int CONTROL_BIT_WIDTH = DEF_CONTROL_BIT_WIDTH,
  parameter int CNT_W             = DEF_CNT_W,
  localparam int SEL_IW     = $clog2(N_INPUTS),
  localparam int SEL_OW     = $clog2(N_OUTPUTS),
  localparam int SEL_REQ_W  = SEL_IW + SEL_OW + CNT_W,
  localparam int SEL_RESP_W = 1 + SEL_IW + SEL_OW
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [SEL_REQ_W-1:0]         req_msg,
  input  logic                         req_val,
  output logic                         req_rdy,
  output logic [CONTROL_BIT_WIDTH-1:0] control,
  output logic                         control_val,
  input  logic                         control_rdy,
  input  logic                         xfer_fire,
  output logic [SEL_RESP_W-1:0]        resp_msg,
  output logic                         resp_val,
  input  logic                         resp_rdy,
  output logic                         busy
);

  logic [SEL_IW-1:0] req_in;
  logic [SEL_OW-1:0] req_out;
  logic [CNT_W-1:0]  req_count;
  logic              req_bad;
  logic [CONTROL_BIT_WIDTH-1:0] ctrl_word;

  assign req_in    = req_msg[SEL_REQ_W-1 -: SEL_IW];
  assign req_out   = req_msg[SEL_REQ_W-1-SEL_IW -: SEL_OW];
  assign req_count = req_msg[CNT_W-1:0];
  assign req_bad   = (32'(req_in) >= 32'(N_INPUTS)) || (32'(req_out) >= 32'(N_OUTPUTS));
  assign ctrl_word = CONTROL_BIT_WIDTH'(pack_control(CONTROL_BIT_WIDTH, SEL_IW, SEL_OW,
                                                     32'(req_in), 32'(req_out)));

  state_t                       state_reg;
  logic                         req_rdy_reg;
  logic [CONTROL_BIT_WIDTH-1:0] control_reg;
  logic                         control_val_reg;
  logic [SEL_RESP_W-1:0]        resp_msg_reg;
  logic                         resp_val_reg;
  logic                         busy_reg;
  logic                         err_reg;
  logic [SEL_IW-1:0]            in_reg;
  logic [SEL_OW-1:0]            out_reg;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;
  logic cnt_one;

  assign cnt_load = (state_reg == IDLE) && req_val;
  assign cnt_dec  = (state_reg == ACTIVE) && xfer_fire;

  xbar_route_counter #(
    .W(CNT_W)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (req_count),
    .dec      (cnt_dec),
    .is_zero  (cnt_zero),
    .is_one   (cnt_one)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      req_rdy_reg     <= 1'b1;
      control_reg     <= '0;
      control_val_reg <= 1'b0;
      resp_msg_reg    <= '0;
      resp_val_reg    <= 1'b0;
      busy_reg        <= 1'b0;
      err_reg         <= 1'b0;
      in_reg          <= '0;
      out_reg         <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_val) begin
            in_reg      <= req_in;
            out_reg     <= req_out;
            req_rdy_reg <= 1'b0;
            busy_reg    <= 1'b1;
            if (req_bad) begin
              // Illegal route: answer with an error and never touch the crossbar.
              err_reg      <= 1'b1;
              state_reg    <= RESP;
              resp_val_reg <= 1'b1;
              resp_msg_reg <= {1'b1, req_in, req_out};
            end else begin
              err_reg         <= 1'b0;
              state_reg       <= ISSUE;
              control_val_reg <= 1'b1;
              control_reg     <= ctrl_word;
            end
          end
        end
        ISSUE: begin
          if (control_rdy) begin
            control_val_reg <= 1'b0;
            control_reg     <= '0;
            if (cnt_zero) begin
              state_reg    <= RESP;
              resp_val_reg <= 1'b1;
              resp_msg_reg <= {err_reg, in_reg, out_reg};
            end else begin
              state_reg <= ACTIVE;
            end
          end
        end
        ACTIVE: begin
          if (xfer_fire && cnt_one) begin
            state_reg    <= RESP;
            resp_val_reg <= 1'b1;
            resp_msg_reg <= {err_reg, in_reg, out_reg};
          end
        end
        RESP: begin
          if (resp_rdy) begin
            state_reg    <= IDLE;
            resp_val_reg <= 1'b0;
            resp_msg_reg <= '0;
            req_rdy_reg  <= 1'b1;
            busy_reg     <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_rdy     = req_rdy_reg;
  assign control     = control_reg;
  assign control_val = control_val_reg;
  assign resp_msg    = resp_msg_reg;
  assign resp_val    = resp_val_reg;
  assign busy        = busy_reg;

endmodule
